fifo_v3: RTL and testbench

//  Parametrised successor of the BRAM stream FIFO with first-word-fall-through output.
//  out_data is valid whenever out_valid=1, and transfers follow standard valid/ready rules.

---
 rtl/fifo_v3_pkg.sv | 7 +
 rtl/fifo_v3_if.sv | 29 ++
 rtl/dualport_ram.sv | 19 +
 rtl/fifo_v3_prefetch_skid.sv | 37 +++
 rtl/fifo_v3.sv | 71 +++++++
 tb/tb_fifo_v3.sv | 112 +++++++++++
 6 files changed

// File: rtl/fifo_v3_pkg.sv
// fifo_v3_pkg: shared constants and sizing helper for the stream FIFO family.
package fifo_v3_pkg;
  localparam int STREAMIF_FIFO_MIN_ADDR = 2;
  function automatic int level_width(input int addr_size);
    return $clog2(2 ** addr_size) + 1;
  endfunction
endpackage

// File: rtl/fifo_v3_if.sv
// fifo_v3_if: write/read handshake, flush and status bundle of fifo_v3.
interface fifo_v3_if
  import fifo_v3_pkg::*;
#(
  parameter int DW  = 64,
  parameter int D2W = 1,
  parameter int LW  = level_width(9)
);
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [D2W-1:0] in_data_2;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [D2W-1:0] out_data_2;
  logic [LW-1:0]  level;
  logic           almost_full;
  logic           almost_empty;
  modport slave (
    input  flush, in_valid, in_data, in_data_2, out_ready,
    output in_ready, out_valid, out_data, out_data_2, level, almost_full, almost_empty
  );
  modport master (
    output flush, in_valid, in_data, in_data_2, out_ready,
    input  in_ready, out_valid, out_data, out_data_2, level, almost_full, almost_empty
  );
endinterface

// File: rtl/dualport_ram.sv
// dualport_ram: simple dual-port RAM, port A write, port B registered read (1 clk latency).
module dualport_ram #(
  parameter int W = 8,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         wea,
  input  logic [A-1:0] addra,
  input  logic [W-1:0] dia,
  input  logic         reb,
  input  logic [A-1:0] addrb,
  output logic [W-1:0] dob
);
  logic [W-1:0] r_mem [2**A];
  always_ff @(posedge clk) begin
    if (wea) r_mem[addra] <= dia;
    if (reb) dob <= r_mem[addrb];
  end
endmodule

// File: rtl/fifo_v3_prefetch_skid.sv
// fifo_prefetch_skid: 2-entry first-word-fall-through stage fed by a 1-clk-latency RAM read.
module fifo_prefetch_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_avail,
  input  logic         i_pop,
  input  logic [W-1:0] i_dob,
  output logic         o_reb,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic [W-1:0] r_mem [2];
  logic         r_head;
  logic         r_inflight;
  logic [1:0]   r_cnt;
  logic [1:0]   w_cnt_nxt;
  // occupancy plus in-flight never exceeds 2, so a landing word always has a free slot
  assign w_cnt_nxt = r_cnt + {1'b0, r_inflight} - {1'b0, i_pop};
  assign o_reb     = i_avail & ~i_clr & (w_cnt_nxt < 2'd2);
  assign o_valid   = r_cnt != 2'd0;
  assign o_data    = r_mem[r_head];
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_head     <= 1'b0;
      r_cnt      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_head     <= r_head ^ i_pop;
      r_cnt      <= w_cnt_nxt;
      r_inflight <= o_reb;
    end
  end
  always_ff @(posedge clk)
    if (r_inflight) r_mem[r_head ^ r_cnt[0]] <= i_dob;
endmodule

// File: rtl/fifo_v3.sv
// fifo_v3: BRAM stream FIFO with FWFT prefetch, fill level, threshold flags and flush.
module fifo_v3
  import fifo_v3_pkg::*;
#(
  parameter int C_DATA_WIDTH     = 64,
  parameter int C_DATA_2_WIDTH   = 1,
  parameter int C_FIFO_ADDR_SIZE = 9,
  parameter int C_AFULL_MARGIN   = 4,
  parameter int C_AEMPTY_LEVEL   = 4
) (
  input  logic      clk,
  input  logic      reset,
  fifo_v3_if.slave  bus
);
  localparam int A = C_FIFO_ADDR_SIZE;
  localparam int W = C_DATA_WIDTH + C_DATA_2_WIDTH;
  localparam logic [A:0] L_FULL = {1'b1, {A{1'b0}}};
  localparam logic [A:0] L_AF   = L_FULL - C_AFULL_MARGIN[A:0];
  localparam logic [A:0] L_AE   = C_AEMPTY_LEVEL[A:0];
  if (C_FIFO_ADDR_SIZE < STREAMIF_FIFO_MIN_ADDR) begin : g_bad_size
    $error("fifo_v3: C_FIFO_ADDR_SIZE below minimum");
  end
  logic [A:0]   r_wptr, r_rptr, r_level, w_level_nxt;
  logic         r_afull, r_aempty;
  logic         w_clr, w_push, w_pop, w_reb;
  logic [W-1:0] w_dob, w_head;
  assign w_clr        = reset | bus.flush;
  assign bus.in_ready = (r_level != L_FULL) & ~bus.flush;
  assign w_push       = bus.in_valid & bus.in_ready;
  assign w_pop        = bus.out_valid & bus.out_ready;
  assign w_level_nxt  = r_level + {{A{1'b0}}, w_push} - {{A{1'b0}}, w_pop};
  assign bus.level        = r_level;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.out_data     = w_head[C_DATA_WIDTH-1:0];
  assign bus.out_data_2   = w_head[W-1:C_DATA_WIDTH];
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_wptr   <= r_wptr + {{A{1'b0}}, w_push};
      r_rptr   <= r_rptr + {{A{1'b0}}, w_reb};
      r_level  <= w_level_nxt;
      r_afull  <= w_level_nxt >= L_AF;
      r_aempty <= w_level_nxt <= L_AE;
    end
  end
  dualport_ram #(.W(W), .A(A)) u_ram (
    .clk   (clk),
    .wea   (w_push),
    .addra (r_wptr[A-1:0]),
    .dia   ({bus.in_data_2, bus.in_data}),
    .reb   (w_reb),
    .addrb (r_rptr[A-1:0]),
    .dob   (w_dob)
  );
  fifo_prefetch_skid #(.W(W)) u_skid (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_avail (r_wptr != r_rptr),
    .i_pop   (w_pop),
    .i_dob   (w_dob),
    .o_reb   (w_reb),
    .o_valid (bus.out_valid),
    .o_data  (w_head)
  );
endmodule

// File: tb/tb_fifo_v3.sv
// tb_fifo_v3: directed and random stimulus against a queue-based reference of fifo_v3.
module tb_fifo_v3;
  localparam int DEPTH = 4;
  typedef struct {
    logic [15:0] d;
    logic        s;
    int          t;
  } ent_t;
  logic clk = 1'b0;
  logic reset;
  ent_t q[$];
  int   n_edge = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_pop  = 0;
  fifo_v3_if #(.DW(16), .D2W(1), .LW(3)) bus ();
  fifo_v3 #(
    .C_DATA_WIDTH     (16),
    .C_DATA_2_WIDTH   (1),
    .C_FIFO_ADDR_SIZE (2),
    .C_AFULL_MARGIN   (1),
    .C_AEMPTY_LEVEL   (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // one clock: check outputs against the reference, clock, then advance the reference
  task automatic step(input logic iv, input logic [15:0] d, input logic s,
                      input logic ordy, input logic fl, input logic rs);
    logic ev, er, pu, po;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_data_2 = s;
    bus.out_ready = ordy;
    bus.flush     = fl;
    reset         = rs;
    #1;
    ev = (q.size() > 0) && (n_edge - q[0].t >= 2);
    er = (q.size() != DEPTH) && !fl;
    if (!rs) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, er});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
      if (ev) chk("out_data", {15'd0, bus.out_data_2, bus.out_data}, {15'd0, q[0].s, q[0].d});
    end
    pu = iv && er;
    po = ev && ordy;
    @(posedge clk);
    n_edge++;
    #1;
    if (rs || fl) q.delete();
    else begin
      if (po) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (pu) q.push_back('{d: d, s: s, t: n_edge});
    end
    chk("level", {29'd0, bus.level}, q.size());
    chk("almost_full", {31'd0, bus.almost_full}, {31'd0, q.size() >= DEPTH - 1});
    chk("almost_empty", {31'd0, bus.almost_empty}, {31'd0, q.size() <= 1});
  endtask
  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 16'd0, 1'b0, ordy, 1'b0, 1'b0);
  endtask
  initial begin
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    // single word through an empty FIFO
    step(1'b1, 16'hA1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    // fill to DEPTH, reject a fifth, drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);
    // streaming across pointer wrap
    for (int i = 0; i < 24; i++) step(i < 20, 16'(i), 1'(i >> 1), 1'b1, 1'b0, 1'b0);
    // full with push+pop together: pop only, then sustained push+pop at 3
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h50 + i), 1'b1, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b1);
    // flush with a RAM read in flight, then a fresh word must come out first
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h77, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);
    // random traffic with back-pressure and rare flushes
    n_pop = 0;
    for (int c = 0; c < 3000 && n_pop < 200; c++)
      step($urandom_range(3, 0) != 0, 16'($urandom), 1'($urandom),
           $urandom_range(2, 0) != 0, $urandom_range(150, 0) == 0, 1'b0);
    chk("random_pops", {31'd0, n_pop >= 200}, 32'd1);
    // reset mid-burst drops everything
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h90 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
